// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline register with a one-entry skid buffer.
// in_ready is a registered signal (!skid valid), so there is no combinational
// path from out_ready back to in_ready. Stage flush squashes held beats.
// Optional feature macro: PIPE_SKID_STALL_CNT_EN enables a saturating
// stall-cycle counter on stall_cnt; without it stall_cnt is tied to zero.
module pipe_skid_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    // Occupancy encoding {skid_valid, main_valid}; 2'b10 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic             r_main_vld_p1;
    logic             r_skid_vld_p1;
    logic [WIDTH-1:0] r_main_data_p1;
    logic [WIDTH-1:0] r_skid_data_p1;

    logic [1:0]       w_state;
    logic             w_in_acc;
    logic             w_out_acc;
    logic             w_nxt_main_vld;
    logic             w_nxt_skid_vld;
    logic             w_ld_main_in;
    logic             w_ld_main_skid;
    logic             w_ld_skid_in;

    assign w_state   = {r_skid_vld_p1, r_main_vld_p1};
    assign in_ready  = ~r_skid_vld_p1;
    assign w_in_acc  = in_valid & ~r_skid_vld_p1;
    assign w_out_acc = r_main_vld_p1 & out_ready;

    assign out_valid = r_main_vld_p1;
    assign out_data  = r_main_data_p1;

    // Next occupancy and payload-load selects from the current handshakes.
    always_comb begin
        w_nxt_main_vld = r_main_vld_p1;
        w_nxt_skid_vld = r_skid_vld_p1;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid_in   = 1'b0;
        case (w_state)
            ST_EMPTY: begin
                if (w_in_acc) begin
                    w_nxt_main_vld = 1'b1;
                    w_ld_main_in   = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_acc && w_out_acc) begin
                    w_ld_main_in = 1'b1;
                end else if (w_in_acc) begin
                    // Downstream stalled: park the new beat behind main.
                    w_nxt_skid_vld = 1'b1;
                    w_ld_skid_in   = 1'b1;
                end else if (w_out_acc) begin
                    w_nxt_main_vld = 1'b0;
                end
            end
            ST_FULL: begin
                if (w_out_acc) begin
                    w_nxt_skid_vld = 1'b0;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: begin
                w_nxt_main_vld = 1'b0;
                w_nxt_skid_vld = 1'b0;
            end
        endcase
        // Squash: drop everything held plus any beat offered this cycle.
        if (flush) begin
            w_nxt_main_vld = 1'b0;
            w_nxt_skid_vld = 1'b0;
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid_in   = 1'b0;
        end
    end

    // Occupancy flags; clr takes priority over flush and handshakes.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_main_vld_p1 <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
        end else begin
            r_main_vld_p1 <= w_nxt_main_vld;
            r_skid_vld_p1 <= w_nxt_skid_vld;
        end
    end

    // Payload registers; cleared by clr only, untouched by flush.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_main_data_p1 <= '0;
            r_skid_data_p1 <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main_data_p1 <= in_data;
            end else if (w_ld_main_skid) begin
                r_main_data_p1 <= r_skid_data_p1;
            end
            if (w_ld_skid_in) begin
                r_skid_data_p1 <= in_data;
            end
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_W'(1));
    endfunction

    // Count edges where a beat is presented but downstream refuses it.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_stall_cnt <= '0;
        end else if (r_main_vld_p1 && !out_ready) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: queue-based occupancy model checked every
// cycle, plus directed vectors with literal expectations.
module tb_pipe_skid_reg;

    localparam int W     = 32;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mq[$];
    int           mcnt = 0;
    int           n_in = 0;
    bit           started = 1'b0;

    pipe_skid_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO holding at most two beats; it accepts only
    // when it held fewer than two at the start of the cycle.
    always @(posedge clk) begin
        int  sz;
        bit  ia, oa;
        if (clr) begin
            mq.delete();
            mcnt    = 0;
            started = 1'b1;
        end else if (started) begin
            sz = mq.size();
            ia = in_valid && (sz < 2);
            oa = (sz > 0) && out_ready;
`ifdef PIPE_SKID_STALL_CNT_EN
            if (sz > 0 && !out_ready && mcnt != CMAX) mcnt++;
`endif
            if (oa) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (ia) begin
                mq.push_back(in_data);
                n_in++;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("m_out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
            chk("m_in_ready",  {63'd0, in_ready},  {63'd0, mq.size() < 2});
            chk("m_stall_cnt", 64'(stall_cnt), 64'(mcnt));
            if (mq.size() > 0) chk("m_out_data", 64'(out_data), 64'(mq[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        bit drained;

        // Reset
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_data",  64'(out_data), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Streaming 1..10 with out_ready high
        for (int i = 1; i <= 10; i++) begin
            in_valid  = 1'b1;
            in_data   = W'(i);
            out_ready = 1'b1;
            step();
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_data",  64'(out_data), 64'(i));
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", {63'd0, out_valid}, 64'd0);

        // Back-pressure: 0xA held, offer 0xB then 0xC
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        chk("bp_a_data", 64'(out_data), 64'hA);
        chk("bp_a_rdy",  {63'd0, in_ready}, 64'd1);
        in_data = 32'hB;
        step();
        chk("bp_b_rdy",  {63'd0, in_ready}, 64'd0);
        chk("bp_b_data", 64'(out_data), 64'hA);
        in_data = 32'hC;
        step();
        chk("bp_c_rdy",  {63'd0, in_ready}, 64'd0);
        chk("bp_c_data", 64'(out_data), 64'hA);
        out_ready = 1'b1;
        step();
        chk("bp_rel_b",   64'(out_data), 64'hB);
        chk("bp_rel_rdy", {63'd0, in_ready}, 64'd1);
        step();
        chk("bp_rel_c", 64'(out_data), 64'hC);
        in_valid = 1'b0;
        step();
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Flush from FULL with a beat offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        chk("fl_full", {63'd0, in_ready}, 64'd0);
        flush   = 1'b1;
        in_data = 32'h33;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("fl_no33", {63'd0, out_valid}, 64'd0);

        // Flush from ONE: offered beat dropped although in_ready=1
        in_valid = 1'b1;
        in_data  = 32'h44;
        step();
        chk("fl1_data", 64'(out_data), 64'h44);
        flush   = 1'b1;
        in_data = 32'h55;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl1_valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("fl1_no55", {63'd0, out_valid}, 64'd0);

        // Stall counter saturation
        in_valid = 1'b1;
        in_data  = 32'h66;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
`ifdef PIPE_SKID_STALL_CNT_EN
        chk("stall_sat", 64'(stall_cnt), 64'd15);
`else
        chk("stall_off", 64'(stall_cnt), 64'd0);
`endif
        chk("stall_hold", 64'(out_data), 64'h66);

        // Reset mid-stream from FULL
        in_valid = 1'b1;
        in_data  = 32'h77;
        step();
        chk("mr_full", {63'd0, in_ready}, 64'd0);
        in_valid  = 1'b0;
        clr       = 1'b1;
        out_ready = 1'b1;
        step();
        clr = 1'b0;
        chk("mr_valid", {63'd0, out_valid}, 64'd0);
        chk("mr_data",  64'(out_data), 64'd0);
        chk("mr_ready", {63'd0, in_ready}, 64'd1);
        chk("mr_cnt",   64'(stall_cnt), 64'd0);

        // Random traffic with occasional flush, checked by the model
        n_in = 0;
        cyc  = 0;
        while (n_in < 1000 && cyc < 20000) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = $urandom;
            out_ready = $urandom_range(0, 1) == 1;
            flush     = $urandom_range(0, 31) == 0;
            step();
            cyc++;
        end
        chk("rand_beats_done", {63'd0, n_in >= 1000}, 64'd1);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drained   = 1'b0;
        for (int i = 0; i < 5 && !drained; i++) begin
            step();
            if (!out_valid) drained = 1'b1;
        end
        chk("rand_drain", {63'd0, drained}, 64'd1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
